// File: rtl/pfc_pkg.sv
// Shared types and default sizing for the pixel frame capture sink.
package pfc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDone
  } pfc_state_e;

  localparam int unsigned PixelsPerFrame = 1024;
  localparam int unsigned AddrW          = 8;
  localparam int unsigned CntW           = 11;
  localparam int unsigned ChecksumW      = 16;
  localparam int unsigned LaneW          = 2;

endpackage

// File: rtl/pixel_frame_capture_if.sv
// Pixel stream handshake plus frame-buffer read port between a source and the capture sink.
interface pixel_frame_capture_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic [7:0]        pixel_in;
  logic              valid_in;
  logic              ready_out;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;

  modport master (
    output pixel_in,
    output valid_in,
    input  ready_out,
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  pixel_in,
    input  valid_in,
    output ready_out,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/pfc_word_ram.sv
// Simple dual-port word buffer: one write port, one registered read port that returns
// the pre-write contents when both ports hit the same address.
module pfc_word_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [31:0]       rd_data_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem_q [Depth];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Array contents are never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pixel_frame_capture.sv
// Frame capture sink: packs four 8-bit pixels per 32-bit buffer word, tracks count and
// checksum, and exposes the buffer through a one-cycle-latency read port.
module pixel_frame_capture
  import pfc_pkg::*;
#(
  parameter int unsigned PIXELS_PER_FRAME = PixelsPerFrame,
  parameter int unsigned ADDR_W           = AddrW,
  parameter int unsigned CNT_W            = CntW
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  hold,
  pixel_frame_capture_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pixel_count,
  output logic [ChecksumW-1:0]  checksum
);

  localparam logic [CNT_W-1:0] FrameCount = CNT_W'(PIXELS_PER_FRAME);

  pfc_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ChecksumW-1:0] csum_q, csum_d;
  logic [23:0]          pack_q, pack_d;
  logic                 rd_valid_q;

  logic                 xfer;
  logic [LaneW-1:0]     lane;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [31:0]          wr_data;

  assign bus.ready_out = (state_q == StCapture) && !hold;
  assign xfer          = bus.valid_in && bus.ready_out;
  assign lane          = count_q[LaneW-1:0];

  // Lane 3 bypasses the pack register so a word commits on the same edge as its last byte.
  assign wr_en   = xfer && (lane == {LaneW{1'b1}});
  assign wr_addr = ADDR_W'(count_q >> LaneW);
  assign wr_data = {bus.pixel_in, pack_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    csum_d  = csum_q;
    pack_d  = pack_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCapture;
          count_d = '0;
          csum_d  = '0;
          pack_d  = '0;
        end
      end
      StCapture: begin
        if (xfer) begin
          count_d = count_q + CNT_W'(1);
          csum_d  = csum_q + ChecksumW'(bus.pixel_in);
          case (lane)
            2'd0:    pack_d[7:0]   = bus.pixel_in;
            2'd1:    pack_d[15:8]  = bus.pixel_in;
            2'd2:    pack_d[23:16] = bus.pixel_in;
            default: pack_d        = pack_q;
          endcase
        end
        // Abort wins over completion: a dropped arm never reports done.
        if (!start) begin
          state_d = StIdle;
        end else if (xfer && (count_d == FrameCount)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      count_q    <= '0;
      csum_q     <= '0;
      pack_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      pack_q     <= pack_d;
      rd_valid_q <= bus.rd_en;
    end
  end

  pfc_word_ram #(
    .ADDR_W (ADDR_W)
  ) u_word_ram (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (bus.rd_en),
    .rd_addr_i (bus.rd_addr),
    .rd_data_o (bus.rd_data)
  );

  assign bus.rd_valid = rd_valid_q;
  assign busy         = (state_q == StCapture);
  assign done         = (state_q == StDone);
  assign pixel_count  = count_q;
  assign checksum     = csum_q;

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Directed bench for pixel_frame_capture: ramp, gapped inverted frame, overrun, abort,
// mid-capture reset and read-port latency.
module tb_pixel_frame_capture;

  localparam int unsigned Ppf = 1024;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        busy;
  logic        done;
  logic [10:0] pixel_count;
  logic [15:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  pixel_frame_capture_if #(.ADDR_W(8)) bus ();

  pixel_frame_capture #(
    .PIXELS_PER_FRAME (Ppf),
    .ADDR_W           (8),
    .CNT_W            (11)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .hold        (hold),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .pixel_count (pixel_count),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    tick();
    bus.rd_en = 1'b0;
    check_eq({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
    check_eq(tag, bus.rd_data, exp);
  endtask

  initial begin
    int   csum;
    int   idx;
    int   cyc;
    logic bad;
    logic v;

    bus.pixel_in = '0;
    bus.valid_in = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;

    // Reset state
    tick();
    tick();
    check_eq("rst_ready", 32'(bus.ready_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_count", 32'(pixel_count), 32'd0);
    check_eq("rst_csum", 32'(checksum), 32'd0);
    check_eq("rst_rdvld", 32'(bus.rd_valid), 32'd0);
    check_eq("rst_rddata", bus.rd_data, 32'd0);
    resetn = 1'b1;
    tick();

    // Ramp frame, one pixel per clock
    start = 1'b1;
    tick();
    check_eq("arm_busy", 32'(busy), 32'd1);
    bad  = 1'b0;
    csum = 0;
    for (int i = 0; i < Ppf; i++) begin
      bus.pixel_in = 8'(i);
      bus.valid_in = 1'b1;
      #1;
      if (bus.ready_out !== 1'b1) bad = 1'b1;
      if (i == Ppf - 1) check_eq("ramp_done_early", 32'(done), 32'd0);
      csum += i % 256;
      tick();
    end
    bus.valid_in = 1'b0;
    check_eq("ramp_ready_high", 32'(bad), 32'd0);
    check_eq("ramp_done", 32'(done), 32'd1);
    check_eq("ramp_busy", 32'(busy), 32'd0);
    check_eq("ramp_count", 32'(pixel_count), 32'd1024);
    check_eq("ramp_csum", 32'(checksum), 32'(csum & 16'hFFFF));
    rd_check("ramp_w0", 8'd0, 32'h03020100);
    rd_check("ramp_w255", 8'd255, 32'hFFFEFDFC);

    // Overrun at done: back-pressured, nothing counted
    bus.valid_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("ovr_ready", 32'(bus.ready_out), 32'd0);
    check_eq("ovr_count", 32'(pixel_count), 32'd1024);
    check_eq("ovr_done", 32'(done), 32'd1);
    bus.valid_in = 1'b0;
    start = 1'b0;
    tick();
    check_eq("disarm_done", 32'(done), 32'd0);
    check_eq("disarm_busy", 32'(busy), 32'd0);
    check_eq("disarm_count_hold", 32'(pixel_count), 32'd1024);

    // Inverted frame with hold every third cycle and random valid gaps
    start = 1'b1;
    tick();
    check_eq("rearm_count", 32'(pixel_count), 32'd0);
    check_eq("rearm_csum", 32'(checksum), 32'd0);
    idx  = 0;
    cyc  = 0;
    csum = 0;
    bad  = 1'b0;
    while (idx < Ppf && cyc < 20000) begin
      hold = (cyc % 3 == 2);
      v    = ($urandom_range(0, 3) != 0);
      bus.valid_in = v;
      bus.pixel_in = 8'(255 - (idx % 256));
      #1;
      if (bus.ready_out !== !hold) bad = 1'b1;
      if (v && !hold) begin
        csum += 255 - (idx % 256);
        idx++;
      end
      tick();
      cyc++;
    end
    hold = 1'b0;
    bus.valid_in = 1'b0;
    check_eq("inv_timeout", 32'(idx), 32'(Ppf));
    check_eq("inv_ready", 32'(bad), 32'd0);
    check_eq("inv_done", 32'(done), 32'd1);
    check_eq("inv_count", 32'(pixel_count), 32'd1024);
    check_eq("inv_csum", 32'(checksum), 32'(csum & 16'hFFFF));
    rd_check("inv_w0", 8'd0, 32'hFCFDFEFF);
    rd_check("inv_w37", 8'd37, 32'h68696A6B);
    rd_check("inv_w255", 8'd255, 32'h00010203);

    // Abort after six pixels; the sixth arrives in the abort cycle
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.pixel_in = 8'(8'h10 + i);
      bus.valid_in = 1'b1;
      if (i == 5) start = 1'b0;
      tick();
    end
    bus.valid_in = 1'b0;
    check_eq("abort_count", 32'(pixel_count), 32'd6);
    check_eq("abort_csum", 32'(checksum), 32'h6F);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ready", 32'(bus.ready_out), 32'd0);
    tick();
    check_eq("abort_done", 32'(done), 32'd0);
    rd_check("abort_w0", 8'd0, 32'h13121110);
    rd_check("abort_w1", 8'd1, 32'hF8F9FAFB);

    // Read latency: single pulse then back-to-back
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'd5;
    tick();
    bus.rd_en = 1'b0;
    check_eq("lat1_vld", 32'(bus.rd_valid), 32'd1);
    check_eq("lat1_data", bus.rd_data, 32'hE8E9EAEB);
    tick();
    check_eq("lat1_vld_drop", 32'(bus.rd_valid), 32'd0);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'd5;
    tick();
    check_eq("b2b_a_vld", 32'(bus.rd_valid), 32'd1);
    check_eq("b2b_a_data", bus.rd_data, 32'hE8E9EAEB);
    bus.rd_addr = 8'd6;
    tick();
    bus.rd_en = 1'b0;
    check_eq("b2b_b_vld", 32'(bus.rd_valid), 32'd1);
    check_eq("b2b_b_data", bus.rd_data, 32'hE4E5E6E7);
    tick();
    check_eq("b2b_vld_drop", 32'(bus.rd_valid), 32'd0);

    // Reset mid-capture, with a same-address read/write collision on word 1
    start = 1'b1;
    tick();
    for (int i = 0; i < 500; i++) begin
      bus.pixel_in = 8'(i);
      bus.valid_in = 1'b1;
      bus.rd_en    = (i == 7);
      bus.rd_addr  = 8'd1;
      if (i == 8) check_eq("collide_old", bus.rd_data, 32'hF8F9FAFB);
      tick();
    end
    bus.valid_in = 1'b0;
    bus.rd_en    = 1'b0;
    check_eq("mid_count", 32'(pixel_count), 32'd500);
    resetn = 1'b0;
    start  = 1'b0;
    tick();
    check_eq("mrst_ready", 32'(bus.ready_out), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_done", 32'(done), 32'd0);
    check_eq("mrst_count", 32'(pixel_count), 32'd0);
    check_eq("mrst_csum", 32'(checksum), 32'd0);
    check_eq("mrst_rdvld", 32'(bus.rd_valid), 32'd0);
    check_eq("mrst_rddata", bus.rd_data, 32'd0);
    resetn = 1'b1;
    tick();
    check_eq("post_rst_ready", 32'(bus.ready_out), 32'd0);
    start = 1'b1;
    tick();
    check_eq("post_arm_ready", 32'(bus.ready_out), 32'd1);
    check_eq("post_arm_count", 32'(pixel_count), 32'd0);
    rd_check("collide_new", 8'd1, 32'h07060504);
    start = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
